// File: rtl/display_pkg.sv
// Shared constants, converter state encoding and BCD helper for the score display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   NUM_DIGITS   - number of seven-segment digits driven
//   BCD_MAX      - largest value representable in four BCD digits
//   AN_OFF       - anode pattern with every digit dark (anodes are active-low)
//   conv_state_t - converter FSM states
//   add3         - double-dabble per-nibble correction
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam int         BCD_MAX    = 9999;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Applied to one nibble in isolation; a nibble >= 5 would overflow past 9
  // once doubled by the following shift, so it is pre-biased by 3.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a one-deep pending request slot.
// Latency: start at cycle N -> SHIFT at N+1, COMMIT (bcd_valid) at N+1+SCORE_W.
// Backpressure: none; starts while busy land in the pending slot, newest request wins.
//
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   bin        - binary input, sampled when start=1 (values above BCD_MAX saturate)
//   start      - single-cycle conversion request
//   busy       - high in SHIFT and COMMIT
//   bcd        - four BCD digits, valid while bcd_valid=1
//   bcd_valid  - high for the single COMMIT cycle
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int SCORE_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] bin,
  input  logic               start,
  output logic               busy,
  output logic [15:0]        bcd,
  output logic               bcd_valid
);

  localparam int                 SR_W  = 16 + SCORE_W;
  localparam int                 CNT_W = $clog2(SCORE_W + 1);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(SCORE_W - 1);
  localparam logic [31:0]        MAX32 = 32'(BCD_MAX);
  localparam logic [SCORE_W-1:0] SAT_V = SCORE_W'(BCD_MAX);

  conv_state_t        state;
  logic [SR_W-1:0]    sr;        // {bcd[15:0], remaining binary bits}
  logic [SR_W-1:0]    sr_adj;
  logic [CNT_W-1:0]   iter;
  logic               pend_vld;
  logic [SCORE_W-1:0] pend_val;
  logic [SCORE_W-1:0] bin_sat;
  logic               next_vld;
  logic [SCORE_W-1:0] next_val;

  // Clamp at sample time so everything downstream fits in four BCD digits.
  always_comb begin
    bin_sat = bin;
    if (32'(bin) > MAX32) begin
      bin_sat = SAT_V;
    end
  end

  // Correct every BCD nibble before the shift; the binary tail is untouched.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sr_adj[SCORE_W + 4*i +: 4] = add3(sr[SCORE_W + 4*i +: 4]);
    end
  end

  // A strobe arriving in the COMMIT cycle outranks an older pending value and
  // is chained straight into the next conversion.
  assign next_vld = start | pend_vld;
  assign next_val = start ? bin_sat : pend_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      iter     <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (next_vld) begin
            sr       <= {16'd0, next_val};
            iter     <= '0;
            pend_vld <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr   <= {sr_adj[SR_W-2:0], 1'b0};
          iter <= iter + 1'b1;
          if (iter == LAST) begin
            state <= COMMIT;
          end
          if (start) begin
            pend_vld <= 1'b1;
            pend_val <= bin_sat;
          end
        end
        COMMIT: begin
          // sr is held this cycle so the committed digits are stable.
          if (next_vld) begin
            sr       <= {16'd0, next_val};
            iter     <= '0;
            pend_vld <= 1'b0;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign bcd_valid = (state == COMMIT);
  assign bcd       = sr[SR_W-1 -: 16];

endmodule

// File: rtl/score_display.sv
// Binary score to 4-digit multiplexed common-anode seven-segment front end.
// Latency: score_valid at N -> bcd_reg at N+2+SCORE_W -> digit/an one cycle later.
// Backpressure: none; strobes during a conversion queue one deep, newest wins.
//
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-high reset
//   score        - binary score, sampled when score_valid=1
//   score_valid  - single-cycle load strobe
//   busy         - conversion in progress
//   digit        - BCD value of the currently lit digit (to segment7 number input)
//   an           - active-low anode enables, an[0] is the units digit
//
// Build option: define SCORE_DISPLAY_LEADING_BLANK_EN to darken leading zero
// digits (units digit always lit). Undefined shows all four digits.
module score_display
  import display_pkg::*;
#(
  parameter int SCORE_W     = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [3:0]         digit,
  output logic [3:0]         an
);

  localparam int               RCNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

  logic [RCNT_W-1:0] rcnt;
  logic [1:0]        idx;
  logic [15:0]       bcd_reg;
  logic [15:0]       conv_bcd;
  logic              conv_valid;
  logic [3:0]        sel_nib;
  logic [3:0]        an_nxt;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W)
  ) u_conv (
    .clk       (clk),
    .rst       (rst),
    .bin       (score),
    .start     (score_valid),
    .busy      (busy),
    .bcd       (conv_bcd),
    .bcd_valid (conv_valid)
  );

  // Only fully converted values reach bcd_reg, so the scan never shows a
  // value mid-conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_reg <= '0;
    end else if (conv_valid) begin
      bcd_reg <= conv_bcd;
    end
  end

  // Refresh timer: idx moves on to the next digit each time the timer wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= 2'd0;
    end else if (rcnt == RCNT_LAST) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign sel_nib = bcd_reg[{idx, 2'b00} +: 4];

`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
  // Position of the most significant nonzero digit; 0 when the value is 0,
  // which keeps the units digit lit for a zero score.
  logic [1:0] msd;

  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] != 4'd0) begin
        msd = 2'(i);
      end
    end
  end

  assign an_nxt = (idx > msd) ? AN_OFF : ~(4'b0001 << idx);
`else
  assign an_nxt = ~(4'b0001 << idx);
`endif

  // digit and an come from the same idx in the same register stage, so they
  // always switch together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= 4'd0;
      an    <= AN_OFF;
    end else begin
      digit <= sel_nib;
      an    <= an_nxt;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with a short refresh period.
// Expected display contents come from decimal arithmetic on the saturated score.
module tb_score_display;

  localparam int SCORE_W = 14;
  localparam int RDIV    = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [SCORE_W-1:0] score = '0;
  logic               score_valid = 1'b0;
  logic               busy;
  logic [3:0]         digit;
  logic [3:0]         an;

  int checks = 0;
  int errors = 0;

  score_display #(
    .SCORE_W     (SCORE_W),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .digit       (digit),
    .an          (an)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int sat(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int dec_digit(int v, int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (sat(v) / p) % 10;
  endfunction

  function automatic logic [15:0] bcd_of(int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(dec_digit(v, i));
    return r;
  endfunction

  function automatic logic [3:0] lit_mask(int v);
    logic [3:0] m;
`ifdef SCORE_DISPLAY_LEADING_BLANK_EN
    int p;
    m = 4'b0001;
    p = 10;
    for (int i = 1; i < 4; i++) begin
      if (sat(v) >= p) m[i] = 1'b1;
      p = p * 10;
    end
`else
    m = 4'b1111;
`endif
    return m;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pulse(int v);
    @(negedge clk);
    score       = SCORE_W'(v);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b, expected 0 within 100 cycles", tag, busy);
    end
  endtask

  task automatic convert(int v, string tag);
    pulse(v);
    wait_idle(tag);
    repeat (2) @(negedge clk);
    checks++;
    if (dut.bcd_reg !== bcd_of(v)) begin
      errors++;
      $display("FAIL %s_bcd_reg score=%0d got %h expected %h", tag, v, dut.bcd_reg, bcd_of(v));
    end
  endtask

  // Watches one full scan period and checks every lit slot and blank count.
  task automatic check_display(int v, string tag);
    logic [3:0]  lit;
    logic [3:0]  seen;
    logic [15:0] exp;
    int          blanks;
    lit    = lit_mask(v);
    exp    = bcd_of(v);
    seen   = 4'b0000;
    blanks = 0;
    for (int c = 0; c < 4 * RDIV; c++) begin
      int pos;
      @(negedge clk);
      pos = -1;
      for (int i = 0; i < 4; i++) if (an === ~(4'b0001 << i)) pos = i;
      checks++;
      if (pos >= 0) begin
        seen[pos] = 1'b1;
        if (!lit[pos] || digit !== exp[4*pos +: 4]) begin
          errors++;
          $display("FAIL %s_digit score=%0d an=%b got digit %0d expected %0d lit=%b",
                   tag, v, an, digit, exp[4*pos +: 4], lit);
        end
      end else if (an === 4'b1111) begin
        blanks++;
      end else begin
        errors++;
        $display("FAIL %s_an_code got an=%b expected one-hot-zero or 1111", tag, an);
      end
    end
    checks++;
    if (seen !== lit || blanks != 4 * (4 - $countones(lit))) begin
      errors++;
      $display("FAIL %s_scan score=%0d got lit=%b blanks=%0d expected lit=%b blanks=%0d",
               tag, v, seen, blanks, lit, 4 * (4 - $countones(lit)));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [3:0] exp_an;
    #1 rst = 1'b1;
    #11;
    checks++;
    if (an !== 4'b1111 || digit !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got an=%b digit=%0d busy=%b expected 1111 0 0", an, digit, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k - 1) / 4));
      checks++;
      if (an !== exp_an || digit !== 4'd0) begin
        errors++;
        $display("FAIL reset_scan cycle %0d got an=%b digit=%0d expected an=%b digit=0", k, an, digit, exp_an);
      end
    end
    // Reset during a conversion with a request pending.
    for (int t = 0; t <= 6; t++) begin
      @(negedge clk);
      score_valid = (t == 0 || t == 3);
      score       = (t == 0) ? SCORE_W'(1234) : SCORE_W'(5678);
    end
    score_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || digit !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got an=%b digit=%0d busy=%b expected 1111 0 0", an, digit, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dut.bcd_reg !== 16'h0000) begin
      errors++;
      $display("FAIL reset_discard got busy=%b bcd_reg=%h expected 0 0000", busy, dut.bcd_reg);
    end
  endtask

  task automatic test_latency;
    for (int t = 0; t <= 17; t++) begin
      @(negedge clk);
      if (t > 0) begin
        checks++;
        if (busy !== (t <= 15)) begin
          errors++;
          $display("FAIL latency_busy cycle N+%0d got %b expected %b", t, busy, (t <= 15));
        end
        if (t >= 15) begin
          checks++;
          if (dut.bcd_reg !== ((t == 15) ? 16'h0000 : 16'h1234)) begin
            errors++;
            $display("FAIL latency_bcd cycle N+%0d got %h expected %h", t, dut.bcd_reg,
                     (t == 15) ? 16'h0000 : 16'h1234);
          end
        end
      end
      score_valid = (t == 0);
      score       = SCORE_W'(1234);
    end
    score_valid = 1'b0;
    check_display(1234, "latency");
  endtask

  task automatic test_saturation;
    int vals[3] = '{12000, 9999, 0};
    foreach (vals[i]) begin
      convert(vals[i], "saturation");
      check_display(vals[i], "saturation");
    end
  endtask

  task automatic test_random;
    int v;
    for (int n = 0; n < 8; n++) begin
      v = int'($urandom_range(0, (1 << SCORE_W) - 1));
      convert(v, "random");
      check_display(v, "random");
    end
  endtask

  task automatic test_leading_blank;
    convert(42, "blank");
    check_display(42, "blank");
    convert(0, "blank");
    check_display(0, "blank");
  endtask

  task automatic test_no_tearing;
    logic prev_new;
    int   pos;
    int   exp;
    convert(1234, "tearing");
    prev_new = 1'b0;
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      if (t > 0) begin
        pos = -1;
        for (int i = 0; i < 4; i++) if (an === ~(4'b0001 << i)) pos = i;
        if (pos >= 0) begin
          exp = prev_new ? dec_digit(5678, pos) : dec_digit(1234, pos);
          checks++;
          if (digit !== 4'(exp)) begin
            errors++;
            $display("FAIL tearing_digit cycle N+%0d an=%b got %0d expected %0d", t, an, digit, exp);
          end
        end
        prev_new = (dut.bcd_reg === bcd_of(5678));
      end
      score_valid = (t == 0);
      score       = SCORE_W'(5678);
    end
    score_valid = 1'b0;
    checks++;
    if (prev_new !== 1'b1) begin
      errors++;
      $display("FAIL tearing_commit got bcd_reg=%h expected %h", dut.bcd_reg, bcd_of(5678));
    end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t <= 32; t++) begin
      @(negedge clk);
      if (t > 0) begin
        checks++;
        if (busy !== (t <= 30)) begin
          errors++;
          $display("FAIL pending_busy cycle N+%0d got %b expected %b", t, busy, (t <= 30));
        end
        checks++;
        if (dut.bcd_reg === bcd_of(77)) begin
          errors++;
          $display("FAIL pending_overwrite cycle N+%0d got bcd_reg=%h expected anything but 0077", t, dut.bcd_reg);
        end
        if (t >= 16) begin
          checks++;
          if (dut.bcd_reg !== ((t <= 30) ? bcd_of(5) : bcd_of(300))) begin
            errors++;
            $display("FAIL pending_bcd cycle N+%0d got %h expected %h", t, dut.bcd_reg,
                     (t <= 30) ? bcd_of(5) : bcd_of(300));
          end
        end
      end
      score_valid = (t == 0 || t == 3 || t == 5);
      score       = (t == 0) ? SCORE_W'(5) : ((t == 3) ? SCORE_W'(77) : SCORE_W'(300));
    end
    score_valid = 1'b0;
    check_display(300, "pending");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_saturation();
    test_random();
    test_leading_blank();
    test_no_tearing();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Sequential front end for the seven-segment path. It takes the game's binary score, converts it to four BCD digits with a multi-cycle double-dabble engine, and time-multiplexes those digits onto a 4-digit common-anode display. Each cycle it presents one 4-bit digit to the `segment7` decoder and drives the matching active-low anode line. It sits between the Tetris score counter and `segment7`.

## Interface
- `SCORE_W`, 14: width of the binary score input.
- `REFRESH_DIV`, 100000: clock cycles each digit stays lit; 100 MHz gives 1 kHz per digit.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset. Asynchronous and active-high.
- `score` input SCORE_W: binary score, sampled when `score_valid`=1.
- `score_valid` input 1: single-cycle load strobe.
- `busy` output 1: conversion in progress.
- `digit` output 4: BCD value (0–9) for the `segment7` `number` input.
- `an` output 4: anode enables, active-low, one-hot-zero; `an[0]` is the units digit.

## Operation
- **Saturation.** If `score` > 9999 at sample time, the block converts 9999.
- **Converter FSM states.**
  - IDLE: waits for a request.
  - SHIFT: runs exactly SCORE_W iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts left by one and brings in the next score MSB.
  - COMMIT: copies the shift register into `bcd_reg[15:0]`, then returns to IDLE.
- **Requests.**
  - `score_valid` in IDLE starts a conversion.
  - `score_valid` during SHIFT or COMMIT stores the value in a one-deep pending register. A newer strobe overwrites the older pending value.
  - On leaving COMMIT, a set pending flag starts the next conversion immediately; IDLE is skipped.
- **Scanning.**
  - A refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - On each wrap, a 2-bit index advances 0→1→2→3→0.
  - `digit` = `bcd_reg` nibble[idx]; `an` = ~(1<<idx).
- **Display source.** The display always reads `bcd_reg` and never the working shift register, so a partially converted value is never shown.
- **Arithmetic.** Add-3 is applied per nibble on a 4-bit value, with no carry between nibbles. The shift register is 16+SCORE_W bits wide.

## Timing
- **Reset values.** `busy`=0, `digit`=0, `an`=4'b1111, `bcd_reg`=0, refresh counter=0, idx=0, pending flag clear, FSM=IDLE.
- **Registered outputs.** `digit` and `an` are registered. The first cycle after reset release shows `an`=4'b1110, `digit`=0.
- **Conversion latency.**
  - `score_valid` at cycle N puts the FSM in SHIFT at N+1.
  - COMMIT is at N+1+SCORE_W.
  - `bcd_reg` updates at N+2+SCORE_W (16 for the default).
  - `digit` reflects the new value one cycle later, if that nibble is currently selected.
- **`busy`.** High from N+1 through the COMMIT cycle inclusive.
- **Simultaneous events.** A `score_valid` in the COMMIT cycle goes to pending. A new conversion never corrupts the commit in progress.
- **Digit switching.** Digits change only on a counter wrap. `an` and `digit` switch in the same cycle, with no intermediate code.
- **Reset mid-conversion.** All state clears immediately and the pending value is discarded.

## Configuration
- **Macro:** `SCORE_DISPLAY_LEADING_BLANK_EN`.
- **Defined:** while idx selects a digit above the most significant nonzero digit of `bcd_reg`, `an` is driven 4'b1111 for that slot.
  - The units digit is never blanked, so score 0 shows a single "0".
  - Example: 42 lights `an[0]` and `an[1]` only.
- **Undefined:** all four digits are always lit, leading zeros included ("0042").

## Structure
- **Package `display_pkg`:** constants `NUM_DIGITS`=4, `BCD_MAX`=9999, `AN_OFF`=4'b1111, and the converter state enum (IDLE, SHIFT, COMMIT).
- **Sub-module `bin2bcd_seq`:** the converter FSM plus pending register.
  - Ports: `clk`, `rst`, `bin`, `start`, `busy`, `bcd`, `bcd_valid`.
- **Top level:** holds the scan counter, `bcd_reg` and the output registers.

## Test plan
- Use REFRESH_DIV=4 for simulation.
1. **Reset:** assert `rst` mid-scan → `an`=1111, `digit`=0, `busy`=0 asynchronously; after release, `an` steps 1110,1101,1011,0111 every 4 cycles.
2. **Latency:** `score`=1234 pulsed at cycle N → `busy` high for 15 cycles; `bcd_reg`=16'h1234 at N+16; scan shows `digit` 4,3,2,1 on `an` 1110,1101,1011,0111.
3. **Saturation:** `score`=12000 → display 9,9,9,9; `score`=9999 → same; `score`=0 → 0,0,0,0 (macro off).
4. **Pending:** pulse 5 at N, 77 at N+3, 300 at N+5 → 5 commits, then 300 converts back-to-back with no IDLE cycle; 77 is never displayed.
5. **Leading blank (macro on):** `score`=42 → `an` sequence 1110,1101,1111,1111; `score`=0 → only `an[0]` lit, `digit`=0.
6. **No tearing:** hold idx on digit 0 while converting 1234→5678 → `digit` changes 4→8 exactly one cycle after `bcd_reg` commits, with no other intermediate value.
